multi_clock_divider: RTL
========================

# multi_clock_divider

Parametrised, multi-channel successor to the fixed single-output divider. It generates NUM_CH independent square-wave clock enables/outputs from one system clock. Each channel has:
- a runtime-programmable half-period, with glitch-free update at the wrap boundary;
- a per-channel enable;
- a single-cycle rising-edge tick strobe.

A global sync input phase-aligns all channels. It sits between the board clock and slow consumers (display scan, debouncers, blinkers), which use either clk_out or tick.

## Interface
Parameters:
- NUM_CH, 4: number of divider channels (≥1).
- CNT_W, 32: counter and half-period width.
- DEFAULT_HALF, 50000: half-period value loaded into every channel at reset.
- CH_W, $clog2(NUM_CH) with minimum 1: width of cfg_ch.

Ports (one clock; reset is synchronous and active-high):
- clk_in  in  1  system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  single-cycle phase-align pulse for all channels.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_half  in  CNT_W  new half-period value H.
- clk_out  out  NUM_CH  divided square wave per channel.
- tick  out  NUM_CH  one-cycle strobe, coincident with each clk_out 0→1.
- pending  out  NUM_CH  a written half-period is waiting for that channel's next wrap.

## Operation
Per-channel state: cnt[CNT_W], half_act, half_shd, pending, clk_out, tick. All outputs are registered.

Priority per clock edge is reset > sync > normal.

**Reset:**
- cnt = 0; clk_out = 0; tick = 0; pending = 0.
- half_act = half_shd = DEFAULT_HALF.
- A config write in the same cycle is discarded.

**Config write** (cfg_we = 1, cfg_ch < NUM_CH, no reset):
- half_shd[cfg_ch] ← cfg_half; pending[cfg_ch] ← 1.
- Writes with cfg_ch ≥ NUM_CH are ignored, with no state change.

**Sync** (no reset), applied to every channel regardless of en:
- cnt = 0; clk_out = 0; tick = 0.
- If pending was set before this cycle: half_act ← half_shd and pending ← 0.
- A write in the same cycle as sync lands in the shadow, sets pending = 1, and applies at the next wrap.

**Normal, en = 1:**
- If cnt ≥ half_act (wrap):
  - cnt ← 0; clk_out toggles; tick ← 1 only if clk_out goes 0→1.
  - If pending: half_act ← half_shd and pending ← 0.
  - If a write to the same channel occurs in this cycle: the new value goes to the shadow, pending stays 1, and it applies at the following wrap.
- Otherwise: cnt ← cnt + 1; tick ← 0.

**Normal, en = 0:**
- cnt, clk_out and half_act hold; tick = 0.
- Writes still go to the shadow.

Other rules:
- Arithmetic is unsigned CNT_W bits. The cnt ≥ half_act compare guarantees cnt never exceeds half_act, so it never overflows.
- H = 0 is legal: clk_out toggles every enabled cycle.
- A new half-period never takes effect mid-half-period. clk_out half-widths are always exactly old H+1 or new H+1 cycles; no runt pulses.

## Timing
- Half-period = H+1 enabled cycles. Full period = 2(H+1) enabled cycles, 50 % duty.
  - DEFAULT_HALF = 50000 → 100002 clk_in cycles.
- With reset asserted at edge k and deasserted afterwards, en held at 1: clk_out rises and tick pulses at edge k+H+1, then clk_out falls at k+2H+2.
- tick is high for exactly 1 cycle per period, in the same cycle clk_out first reads 1.
- A write takes effect in the cycle after the first wrap that follows the write cycle. pending is high from the cycle after the write until that wrap.
- A sync at edge s: clk_out = 0 after edge s, and the first rise is at s+H+1. Channels with equal H and en are thereafter edge-aligned.
- en low for n cycles delays that channel's phase by exactly n cycles.

## Test plan
1. DEFAULT_HALF=3, reset for 2 cycles, then en=4'b1111 → every clk_out rises 4 cycles after reset release and has period 8 (4 high / 4 low); tick is 1 cycle wide on each rise; pending = 0.
2. Write cfg_ch=1, cfg_half=1 two cycles into a half-period → pending[1]=1 immediately after; the current half completes at 4 cycles; from then on ch1 has period 4; pending[1] clears at that wrap; the other channels are unchanged.
3. Drop en[2] for 5 cycles mid-count → clk_out[2] and its count freeze; its next edge arrives exactly 5 cycles later than ch0's; no tick while disabled.
4. Channels at different phases and H (1, 2, 3, 0), then a sync pulse → all clk_out = 0 on the next cycle; each rises H+1 cycles after sync; a pending write applies at sync.
5. Pending write on ch3, then reset mid-operation → outputs 0, pending = 0, half back to DEFAULT_HALF; the write issued in the reset cycle has no effect.
6. cfg_half=0 on ch0 → clk_out[0] toggles every cycle and tick[0] fires every 2nd cycle; a write with cfg_ch=NUM_CH (NUM_CH not a power of 2, e.g. 3) → no state change.

Source files
------------

// File: rtl/multi_clock_divider.sv
// multi_clock_divider: NUM_CH independent square-wave dividers with shadowed half-periods,
// per-channel enable, rising-edge tick strobe and a global phase-align sync.
module multi_clock_divider #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int DEFAULT_HALF = 50000,
    parameter int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in_i,
    input  logic              reset_i,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [CNT_W-1:0]  cfg_half_i,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] pending_o
);
    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [CNT_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
            logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
            logic wr, wrap, step;
            // Shadow only reaches the active half-period at a wrap or sync, so no runt halves.
            always_comb begin
                wr     = cfg_we_i && (cfg_ch_i == CH_W'(c));
                wrap   = cnt_q >= act_q;
                step   = en_i[c] && wrap && !sync_i;
                shd_d  = wr ? cfg_half_i : shd_q;
                pend_d = wr || (pend_q && !(sync_i || step));
                act_d  = ((sync_i || step) && pend_q) ? shd_q : act_q;
                cnt_d  = (sync_i || step) ? '0 : cnt_q + CNT_W'(en_i[c]);
                clk_d  = sync_i ? 1'b0 : step ? !clk_q : clk_q;
                tick_d = step && !clk_q;
            end
            always_ff @(posedge clk_in_i) begin
                if (reset_i) begin
                    cnt_q  <= '0;
                    act_q  <= CNT_W'(DEFAULT_HALF);
                    shd_q  <= CNT_W'(DEFAULT_HALF);
                    pend_q <= 1'b0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    act_q  <= act_d;
                    shd_q  <= shd_d;
                    pend_q <= pend_d;
                    clk_q  <= clk_d;
                    tick_q <= tick_d;
                end
            end
            assign clk_out_o[c] = clk_q;
            assign tick_o[c]    = tick_q;
            assign pending_o[c] = pend_q;
        end
    endgenerate
endmodule
